// File: rtl/rv16_ex_mem_reg.sv
// rv16_ex_mem_reg
//   EX->MEM pipeline register that sits directly after rv16_alu. It captures
//   the ALU result, flags and decoded control into a two-entry valid/ready
//   buffer made of an output register and a skid register. The stage also
//   resolves conditional branches from the ALU compare result, raises a
//   one-cycle fetch redirect, flags signed-overflow traps and counts
//   back-pressure stall cycles.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_valid / o_ready       upstream handshake (o_ready is registered)
//   i_alu_result, i_alu_overflow, i_rd, i_reg_write, i_mem_read,
//   i_mem_write, i_store_data, i_is_branch, i_trap_ovf, i_pc,
//   i_branch_offset         incoming instruction fields
//   i_flush                 drop every buffered and incoming entry
//   o_valid / i_ready       downstream handshake
//   o_result, o_rd, o_reg_write, o_mem_read, o_mem_write, o_store_data,
//   o_exc_ovf               registered output entry
//   o_redirect, o_redirect_pc  one-cycle taken-branch pulse and target
//   o_stall_cnt             saturating count of o_valid & ~i_ready cycles

module rv16_ex_mem_reg #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [XLEN-1:0]       i_alu_result,
  input  logic                  i_alu_overflow,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_reg_write,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [XLEN-1:0]       i_store_data,
  input  logic                  i_is_branch,
  input  logic                  i_trap_ovf,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_branch_offset,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_result,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [XLEN-1:0]       o_store_data,
  output logic                  o_exc_ovf,
  output logic                  o_redirect,
  output logic [XLEN-1:0]       o_redirect_pc,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [XLEN-1:0]       store_data;
    logic                  exc;
  } entry_t;

  state_t               state_q, state_d;
  entry_t               out_q, out_d;
  entry_t               skid_q, skid_d;
  entry_t               in_entry;
  logic                 ready_q, ready_d;
  logic                 redirect_q, redirect_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic                 out_valid;
  logic                 accept;
  logic                 pop;
  logic                 taken;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = i_valid & ready_q;
  assign pop       = out_valid & i_ready;
  assign taken     = i_is_branch & i_alu_result[0];

  // A trapping instruction must not retire architectural writes, so the
  // write enables are killed at capture time rather than downstream.
  always_comb begin
    in_entry            = '0;
    in_entry.exc        = i_trap_ovf & i_alu_overflow;
    in_entry.result     = i_alu_result;
    in_entry.rd         = i_rd;
    in_entry.reg_write  = i_reg_write & ~in_entry.exc;
    in_entry.mem_read   = i_mem_read;
    in_entry.mem_write  = i_mem_write & ~in_entry.exc;
    in_entry.store_data = i_store_data;
  end

  // Buffer control: output register holds the head, skid holds the second
  // entry; o_ready is computed from the next state so it is a plain flop.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          out_d   = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush wins over any simultaneous accept or pop.
    if (i_flush) begin
      state_d = ST_EMPTY;
    end

    ready_d = (state_d != ST_TWO);
  end

  // Redirect pulse comes only from a taken branch actually entering the
  // buffer; an already-pending pulse is left alone by flush.
  always_comb begin
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (accept && taken && !i_flush) begin
      redirect_d    = 1'b1;
      redirect_pc_d = i_pc + i_branch_offset;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !i_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_EMPTY;
      out_q         <= '0;
      skid_q        <= '0;
      ready_q       <= 1'b1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      skid_q        <= skid_d;
      ready_q       <= ready_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = out_valid;
  assign o_result      = out_q.result;
  assign o_rd          = out_q.rd;
  assign o_reg_write   = out_q.reg_write;
  assign o_mem_read    = out_q.mem_read;
  assign o_mem_write   = out_q.mem_write;
  assign o_store_data  = out_q.store_data;
  assign o_exc_ovf     = out_q.exc;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_rv16_ex_mem_reg.sv
// tb_rv16_ex_mem_reg
//   Directed bench for rv16_ex_mem_reg: reset, single transfer, back-pressure
//   ordering, branch redirect, flush, overflow trap and stall-counter
//   saturation, each with hand-computed expected values.

module tb_rv16_ex_mem_reg;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_alu_result;
  logic        i_alu_overflow;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [31:0] i_store_data;
  logic        i_is_branch;
  logic        i_trap_ovf;
  logic [31:0] i_pc;
  logic [31:0] i_branch_offset;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] o_store_data;
  logic        o_exc_ovf;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [15:0] o_stall_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  rv16_ex_mem_reg #(
    .XLEN      (32),
    .REG_ADDR_W(5),
    .CNT_W     (16)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_alu_result   (i_alu_result),
    .i_alu_overflow (i_alu_overflow),
    .i_rd           (i_rd),
    .i_reg_write    (i_reg_write),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_store_data   (i_store_data),
    .i_is_branch    (i_is_branch),
    .i_trap_ovf     (i_trap_ovf),
    .i_pc           (i_pc),
    .i_branch_offset(i_branch_offset),
    .i_flush        (i_flush),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_rd           (o_rd),
    .o_reg_write    (o_reg_write),
    .o_mem_read     (o_mem_read),
    .o_mem_write    (o_mem_write),
    .o_store_data   (o_store_data),
    .o_exc_ovf      (o_exc_ovf),
    .o_redirect     (o_redirect),
    .o_redirect_pc  (o_redirect_pc),
    .o_stall_cnt    (o_stall_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_valid         = 1'b0;
    i_alu_result    = '0;
    i_alu_overflow  = 1'b0;
    i_rd            = '0;
    i_reg_write     = 1'b0;
    i_mem_read      = 1'b0;
    i_mem_write     = 1'b0;
    i_store_data    = '0;
    i_is_branch     = 1'b0;
    i_trap_ovf      = 1'b0;
    i_pc            = '0;
    i_branch_offset = '0;
  endtask

  task automatic send(input logic [31:0] res, input logic [4:0] rd, input logic rw);
    idle_in();
    i_valid      = 1'b1;
    i_alu_result = res;
    i_rd         = rd;
    i_reg_write  = rw;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    idle_in();

    // Reset state
    #12;
    chk("rst_valid",    32'(o_valid), 32'd0);
    chk("rst_ready",    32'(o_ready), 32'd1);
    chk("rst_redirect", 32'(o_redirect), 32'd0);
    chk("rst_rpc",      o_redirect_pc, 32'd0);
    chk("rst_stall",    32'(o_stall_cnt), 32'd0);
    chk("rst_result",   o_result, 32'd0);
    #1 i_rst_n = 1'b1;
    step();

    // Single transfer, latency one cycle
    i_ready = 1'b1;
    send(32'h0000_0005, 5'd3, 1'b1);
    step();
    chk("add_valid",  32'(o_valid), 32'd1);
    chk("add_result", o_result, 32'h5);
    chk("add_rd",     32'(o_rd), 32'd3);
    chk("add_rw",     32'(o_reg_write), 32'd1);
    chk("add_exc",    32'(o_exc_ovf), 32'd0);
    idle_in();
    step();
    chk("add_drain",  32'(o_valid), 32'd0);
    chk("add_stall",  32'(o_stall_cnt), 32'd0);

    // Back-pressure: A in out, B in skid, C held off
    i_ready = 1'b0;
    send(32'hA, 5'd1, 1'b1);
    i_mem_read   = 1'b1;
    i_store_data = 32'hDEAD_BEEF;
    step();
    chk("bp_a_out",   o_result, 32'hA);
    chk("bp_a_mr",    32'(o_mem_read), 32'd1);
    chk("bp_a_sd",    o_store_data, 32'hDEAD_BEEF);
    send(32'hB, 5'd2, 1'b1);
    step();
    chk("bp_two_rdy", 32'(o_ready), 32'd0);
    chk("bp_two_out", o_result, 32'hA);
    send(32'hC, 5'd3, 1'b1);
    step();
    chk("bp_hold_out", o_result, 32'hA);
    chk("bp_hold_rd",  32'(o_rd), 32'd1);
    step();
    chk("bp_stall3",  32'(o_stall_cnt), 32'd3);
    i_ready = 1'b1;
    step();
    chk("bp_b_out",   o_result, 32'hB);
    chk("bp_b_rd",    32'(o_rd), 32'd2);
    chk("bp_b_rdy",   32'(o_ready), 32'd1);
    step();
    chk("bp_c_out",   o_result, 32'hC);
    chk("bp_c_rd",    32'(o_rd), 32'd3);
    idle_in();
    step();
    chk("bp_empty",   32'(o_valid), 32'd0);
    chk("bp_stall_end", 32'(o_stall_cnt), 32'd3);

    // Taken branch with negative offset, then not-taken branch
    send(32'h1, 5'd0, 1'b0);
    i_is_branch     = 1'b1;
    i_pc            = 32'h0000_0100;
    i_branch_offset = 32'hFFFF_FFF0;
    step();
    chk("br_redirect", 32'(o_redirect), 32'd1);
    chk("br_rpc",      o_redirect_pc, 32'h0000_00F0);
    chk("br_flows",    32'(o_valid), 32'd1);
    send(32'h0, 5'd0, 1'b0);
    i_is_branch     = 1'b1;
    i_pc            = 32'h0000_0200;
    i_branch_offset = 32'h0000_0040;
    step();
    chk("br_pulse_end", 32'(o_redirect), 32'd0);
    chk("br_nt_flows",  32'(o_valid), 32'd1);
    idle_in();
    step();
    chk("br_nt_none",  32'(o_redirect), 32'd0);

    // Overflow trap kills writes; overflow without trap does not
    send(32'h7, 5'd9, 1'b1);
    i_trap_ovf     = 1'b1;
    i_alu_overflow = 1'b1;
    i_mem_write    = 1'b1;
    step();
    chk("ovf_exc", 32'(o_exc_ovf), 32'd1);
    chk("ovf_rw",  32'(o_reg_write), 32'd0);
    chk("ovf_mw",  32'(o_mem_write), 32'd0);
    send(32'h8, 5'd9, 1'b1);
    i_alu_overflow = 1'b1;
    step();
    chk("ovf_notrap_exc", 32'(o_exc_ovf), 32'd0);
    chk("ovf_notrap_rw",  32'(o_reg_write), 32'd1);
    idle_in();
    step();

    // Flush from TWO with an incoming taken branch
    i_ready = 1'b0;
    send(32'hD, 5'd4, 1'b1);
    step();
    send(32'hE, 5'd5, 1'b1);
    step();
    chk("fl_two", 32'(o_ready), 32'd0);
    send(32'h1, 5'd6, 1'b1);
    i_is_branch     = 1'b1;
    i_pc            = 32'h0000_1000;
    i_branch_offset = 32'h0000_0010;
    i_flush = 1'b1;
    step();
    chk("fl_valid",    32'(o_valid), 32'd0);
    chk("fl_ready",    32'(o_ready), 32'd1);
    chk("fl_redirect", 32'(o_redirect), 32'd0);
    chk("fl_stall",    32'(o_stall_cnt), 32'd5);
    i_flush = 1'b0;
    idle_in();
    i_ready = 1'b1;
    step();
    step();
    chk("fl_nothing", 32'(o_valid), 32'd0);

    // Asynchronous reset while in TWO
    i_ready = 1'b0;
    send(32'h11, 5'd7, 1'b1);
    step();
    send(32'h22, 5'd8, 1'b1);
    step();
    idle_in();
    chk("ar_two",   32'(o_ready), 32'd0);
    chk("ar_stall", 32'(o_stall_cnt), 32'd6);
    #2 i_rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(o_valid), 32'd0);
    chk("ar_ready", 32'(o_ready), 32'd1);
    chk("ar_cnt",   32'(o_stall_cnt), 32'd0);
    #1 i_rst_n = 1'b1;
    step();

    // Stall counter saturation; output entry must also hold steady
    send(32'h33, 5'd10, 1'b1);
    step();
    idle_in();
    for (int i = 0; i < 65534; i++) step();
    chk("sat_fffe", 32'(o_stall_cnt), 32'h0000_FFFE);
    step();
    chk("sat_ffff", 32'(o_stall_cnt), 32'h0000_FFFF);
    step();
    step();
    step();
    chk("sat_hold", 32'(o_stall_cnt), 32'h0000_FFFF);
    chk("sat_result_held", o_result, 32'h33);
    chk("sat_rd_held",     32'(o_rd), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
